// File: rtl/ppe_pkg.sv
// Shared types and helpers for the packet arbiter: FSM state encoding,
// starvation counter width and the one-hot +1 rotation used for the priority pointer.
package ppe_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int STARVE_W = 8;
    localparam int MAX_N    = 16;

    // Moves a one-hot bit at index i to index (i+1) mod n; bits at or above n are ignored.
    function automatic logic [0:MAX_N-1] rr_rotate(input logic [0:MAX_N-1] v, input int n);
        logic [0:MAX_N-1] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && v[i]) begin
                r[(i + 1) % n] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ppe_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester at or after the
// one-hot priority pointer, wrapping from N-1 back to 0.
module ppe_rr_pick #(
    parameter int N = 4
) (
    input  logic [0:N-1] req_i,
    input  logic [0:N-1] prio_i,
    output logic [0:N-1] pick_o
);

    logic found;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < N; k++) begin
                if (prio_i[s] && !found && req_i[(s + k) % N]) begin
                    pick_o[(s + k) % N] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ppe_packet_arbiter.sv
// Wormhole output-port arbiter: round-robin packet lock held until tail, credit-gated.
// Optional per-requester starvation flags when PPE_ARB_STARVE_CNT_EN is defined.
module ppe_packet_arbiter
    import ppe_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
`ifdef PPE_ARB_STARVE_CNT_EN
    ,
    parameter  int STARVE_LIMIT = 64
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [0:N-1]  i_valid,
    input  logic [0:N-1]  i_tail,
    input  logic          i_credit,
    output logic [0:N-1]  o_grant,
    output logic          o_fire,
    output logic [CW-1:0] o_credits,
    output logic          o_credit_err
`ifdef PPE_ARB_STARVE_CNT_EN
    ,
    output logic [0:N-1]  o_starve
`endif
);

    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
    localparam logic [0:N-1]  PTR_RST     = {1'b1, {(N-1){1'b0}}};

    arb_state_t    state_q, state_d;
    logic [0:N-1]  grant_q, grant_d;
    logic [0:N-1]  ptr_q, ptr_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;

    logic             fire, tail_fire;
    logic [0:N-1]     ptr_rot, pick_ptr, pick_req, pick;
    logic [0:MAX_N-1] grant_pad, rot_pad;
    logic             unused_rot;

    assign fire      = ce && (state_q == LOCKED) && (|(grant_q & i_valid)) && (credits_q != '0);
    assign tail_fire = fire && (|(grant_q & i_tail));

    always_comb begin
        grant_pad        = '0;
        grant_pad[0:N-1] = grant_q;
        rot_pad          = rr_rotate(grant_pad, N);
        ptr_rot          = rot_pad[0:N-1];
    end
    assign unused_rot = ^rot_pad;

    // The owner's valid during its tail fire belongs to the flit just consumed,
    // so it is excluded from the back-to-back re-pick.
    assign pick_ptr = tail_fire ? ptr_rot : ptr_q;
    assign pick_req = tail_fire ? (i_valid & ~grant_q) : i_valid;

    ppe_rr_pick #(.N(N)) u_pick (
        .req_i  (pick_req),
        .prio_i (pick_ptr),
        .pick_o (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_RST;
            credits_q <= CREDITS_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        credits_d = credits_q;
        err_d     = err_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (|i_valid) begin
                        state_d = LOCKED;
                        grant_d = pick;
                    end
                end
                LOCKED: begin
                    if (tail_fire) begin
                        ptr_d = ptr_rot;
                        if (|pick_req) begin
                            grant_d = pick;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Credit returns are honoured even while ce is low.
        if (fire && !i_credit) begin
            credits_d = credits_q - 1'b1;
        end else if (i_credit && !fire) begin
            if (credits_q == CREDITS_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_comb begin
        o_grant      = grant_q;
        o_fire       = fire;
        o_credits    = credits_q;
        o_credit_err = err_q;
    end

`ifdef PPE_ARB_STARVE_CNT_EN
    for (genvar gi = 0; gi < N; gi++) begin : g_starve
        logic [STARVE_W-1:0] cnt_q, cnt_d;
        logic                starve_q;

        always_comb begin
            cnt_d = cnt_q;
            if (ce) begin
                if (!i_valid[gi] || grant_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= '0;
                starve_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                starve_q <= (int'(cnt_d) >= STARVE_LIMIT);
            end
        end

        assign o_starve[gi] = starve_q;
    end
`endif

endmodule
